music_play_ctrl: RTL

Playback sequencer for the music player. It consumes the single-cycle button pulses produced by the per-button synchronizer/edge-detector stages (play/pause, next, prev). It drives the song select and note address into the song ROM, and paces note advance with a beat timer. Downstream tone generation uses song_sel, note_addr and note_strobe.

---
 rtl/music_play_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/music_play_ctrl.sv
// Playback sequencer: walks song/note addresses into the song ROM, paced by a beat timer.
// Latency: 1 cycle from button pulse to state/playing change; 2 cycles from play in IDLE to first note_strobe.
// Backpressure: none; pulses are consumed in the cycle they arrive, and losing events are dropped by priority.
// Ports: clk/r_n (sync active-low reset), play_pulse/next_pulse/prev_pulse (1-cycle buttons),
//        song_end (ROM end marker at note_addr), song_sel/note_addr (ROM address),
//        playing, note_strobe, beat_tick (registered status/pulses).
module music_play_ctrl #(
  parameter int NUM_SONGS   = 4,
  parameter int SONG_W      = 2,
  parameter int ADDR_W      = 8,
  parameter int BEAT_CYCLES = 12500000
) (
  input  logic              clk,
  input  logic              r_n,
  input  logic              play_pulse,
  input  logic              next_pulse,
  input  logic              prev_pulse,
  input  logic              song_end,
  output logic [SONG_W-1:0] song_sel,
  output logic [ADDR_W-1:0] note_addr,
  output logic              playing,
  output logic              note_strobe,
  output logic              beat_tick
);

  localparam int CNT_W = $clog2(BEAT_CYCLES);
  localparam logic [CNT_W-1:0]  BEAT_LAST = CNT_W'(BEAT_CYCLES - 1);
  localparam logic [SONG_W-1:0] SONG_LAST = SONG_W'(NUM_SONGS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_PLAY  = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  beat_cnt, beat_cnt_nxt;
  logic [SONG_W-1:0] song_sel_nxt;
  logic [ADDR_W-1:0] note_addr_nxt;
  logic              strobe_nxt, tick_nxt, playing_nxt;

  // next and prev together cancel out, leaving play_pulse free to act
  logic              song_chg;
  logic [SONG_W-1:0] song_inc, song_dec, song_step;
  logic              beat_last;
  logic              song_done;

  assign song_chg  = next_pulse ^ prev_pulse;
  assign song_inc  = (song_sel == SONG_LAST) ? '0 : song_sel + 1'b1;
  assign song_dec  = (song_sel == '0) ? SONG_LAST : song_sel - 1'b1;
  assign song_step = next_pulse ? song_inc : song_dec;
  assign beat_last = (beat_cnt == BEAT_LAST);
  // last addressable note ends the song even without an end marker
  assign song_done = song_end || (&note_addr);

  always_comb begin
    state_nxt     = state;
    song_sel_nxt  = song_sel;
    note_addr_nxt = note_addr;
    beat_cnt_nxt  = beat_cnt;
    strobe_nxt    = 1'b0;
    tick_nxt      = 1'b0;

    case (state)
      S_IDLE: begin
        note_addr_nxt = '0;
        beat_cnt_nxt  = '0;
        if (song_chg) begin
          song_sel_nxt = song_step;
        end else if (play_pulse) begin
          state_nxt = S_LOAD;
        end
      end

      S_LOAD: begin
        if (song_chg) begin
          // another song change restarts the load on the new song
          song_sel_nxt = song_step;
        end else begin
          note_addr_nxt = '0;
          beat_cnt_nxt  = '0;
          strobe_nxt    = 1'b1;
          state_nxt     = S_PLAY;
        end
      end

      S_PLAY: begin
        if (song_chg) begin
          // song change beats the beat boundary: no advance, no tick
          song_sel_nxt = song_step;
          state_nxt    = S_LOAD;
        end else if (beat_last) begin
          beat_cnt_nxt = '0;
          tick_nxt     = 1'b1;
          if (song_done) begin
            song_sel_nxt = song_inc;
            state_nxt    = S_LOAD;
          end else begin
            note_addr_nxt = note_addr + 1'b1;
            strobe_nxt    = 1'b1;
          end
        end else if (play_pulse) begin
          // pause freezes the beat count where it is, without counting this cycle
          state_nxt = S_PAUSE;
        end else begin
          beat_cnt_nxt = beat_cnt + 1'b1;
        end
      end

      S_PAUSE: begin
        if (song_chg) begin
          song_sel_nxt  = song_step;
          note_addr_nxt = '0;
          beat_cnt_nxt  = '0;
        end else if (play_pulse) begin
          state_nxt = S_PLAY;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    playing_nxt = (state_nxt == S_LOAD) || (state_nxt == S_PLAY);
  end

  always_ff @(posedge clk) begin
    if (!r_n) begin
      state       <= S_IDLE;
      song_sel    <= '0;
      note_addr   <= '0;
      beat_cnt    <= '0;
      playing     <= 1'b0;
      note_strobe <= 1'b0;
      beat_tick   <= 1'b0;
    end else begin
      state       <= state_nxt;
      song_sel    <= song_sel_nxt;
      note_addr   <= note_addr_nxt;
      beat_cnt    <= beat_cnt_nxt;
      playing     <= playing_nxt;
      note_strobe <= strobe_nxt;
      beat_tick   <= tick_nxt;
    end
  end

endmodule
